// File: rtl/seven_led_pkg.sv
// Shared types and constants for the seven-segment sequencing controller.
package seven_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam int          BCD_DIGITS  = 10;
  localparam int          DISP_DIGITS = 8;
  localparam logic [31:0] MAX_VAL_DEF = 32'd99_999_999;

endpackage

// File: rtl/seven_led_ctrl_bcd_add3_step.sv
// One double-dabble correction step: every BCD nibble >= 5 gets +3 before the shift.
module bcd_add3_step
  import seven_led_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_i[4*d +: 4] >= 4'd5) begin
        bcd_o[4*d +: 4] = bcd_i[4*d +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/seven_led_ctrl.sv
// Binary-to-decimal sequencer feeding the 8-digit seven-segment decoder.
// Digits update atomically at the end of a fixed 33-cycle conversion.
module seven_led_ctrl
  import seven_led_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter bit                SAT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] MAX_VAL = DATA_W'(MAX_VAL_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_ni,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [6:0]        o_hex0,
  output logic [6:0]        o_hex1,
  output logic [6:0]        o_hex2,
  output logic [6:0]        o_hex3,
  output logic [6:0]        o_hex4,
  output logic [6:0]        o_hex5,
  output logic [6:0]        o_hex6,
  output logic [6:0]        o_hex7
);

  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int DISP_W = 4 * DISP_DIGITS;
  localparam int CNT_W  = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ovf_out_q, ovf_out_d;
  logic              done_q, done_d;
  logic              start;
  logic [DATA_W-1:0] start_val;

  bcd_add3_step #(.DIGITS(BCD_DIGITS)) u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  always_ff @(posedge i_clk or negedge i_rst_ni) begin
    if (!i_rst_ni) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      ovf_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      ovf_out_q  <= ovf_out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    ovf_out_d  = ovf_out_q;
    done_d     = 1'b0;
    start      = 1'b0;
    start_val  = i_wr_data;

    case (state_q)
      IDLE: start = i_wr_en;
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = LOAD;
        if (i_wr_en) begin
          pend_d     = i_wr_data;
          pend_vld_d = 1'b1;
        end
      end
      LOAD: begin
        disp_d    = (SAT_EN && ovf_q) ? {DISP_DIGITS{4'd9}} : bcd_q[DISP_W-1:0];
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        // A write arriving in this cycle is newer than anything queued.
        if (i_wr_en) begin
          start      = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          start      = 1'b1;
          start_val  = pend_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      bin_d   = start_val;
      bcd_d   = '0;
      cnt_d   = '0;
      ovf_d   = start_val > MAX_VAL;
      state_d = CONV;
    end
  end

  assign o_busy = (state_q != IDLE) || pend_vld_q;
  assign o_done = done_q;
  assign o_ovf  = ovf_out_q;
  assign o_hex0 = {3'b000, disp_q[3:0]};
  assign o_hex1 = {3'b000, disp_q[7:4]};
  assign o_hex2 = {3'b000, disp_q[11:8]};
  assign o_hex3 = {3'b000, disp_q[15:12]};
  assign o_hex4 = {3'b000, disp_q[19:16]};
  assign o_hex5 = {3'b000, disp_q[23:20]};
  assign o_hex6 = {3'b000, disp_q[27:24]};
  assign o_hex7 = {3'b000, disp_q[31:28]};

endmodule

// File: tb/tb_seven_led_ctrl.sv
// Bench for seven_led_ctrl: saturating and modulo instances side by side,
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_seven_led_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;

  logic        busy_s, done_s, ovf_s, busy_m, done_m, ovf_m;
  logic [6:0]  hs [8];
  logic [6:0]  hm [8];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_led_ctrl #(.DATA_W(32), .SAT_EN(1'b1)) dut_s (
    .i_clk(clk), .i_rst_ni(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_busy(busy_s), .o_done(done_s), .o_ovf(ovf_s),
    .o_hex0(hs[0]), .o_hex1(hs[1]), .o_hex2(hs[2]), .o_hex3(hs[3]),
    .o_hex4(hs[4]), .o_hex5(hs[5]), .o_hex6(hs[6]), .o_hex7(hs[7])
  );

  seven_led_ctrl #(.DATA_W(32), .SAT_EN(1'b0)) dut_m (
    .i_clk(clk), .i_rst_ni(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_busy(busy_m), .o_done(done_m), .o_ovf(ovf_m),
    .o_hex0(hm[0]), .o_hex1(hm[1]), .o_hex2(hm[2]), .o_hex3(hm[3]),
    .o_hex4(hm[4]), .o_hex5(hm[5]), .o_hex6(hm[6]), .o_hex7(hm[7])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] disp_s();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = hs[i][3:0];
    return r;
  endfunction

  function automatic logic [31:0] disp_m();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = hm[i][3:0];
    return r;
  endfunction

  function automatic logic [31:0] upper_bits();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r = r | {29'd0, hs[i][6:4]} | {29'd0, hm[i][6:4]};
    return r;
  endfunction

  // Decimal digits of a value as the display must show them, packed hex7..hex0.
  function automatic logic [31:0] to_disp(input logic [31:0] v, input bit sat);
    longint unsigned x;
    logic [31:0] r = '0;
    if (sat && v > 32'd99_999_999) return 32'h9999_9999;
    x = longint'(v) % 64'd100_000_000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  // Transaction-level model: a conversion lasts 33 edges, one queued write, latest wins.
  bit          m_act = 0, m_pend = 0;
  int          m_left = 0;
  logic [31:0] m_val = '0, m_pval = '0;
  logic [31:0] exp_ds = '0, exp_dm = '0;
  logic        exp_ovf = 0, exp_done = 0, exp_busy = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_pend = 0; m_left = 0;
      exp_ds = '0; exp_dm = '0; exp_ovf = 0; exp_done = 0; exp_busy = 0;
    end else begin
      exp_done = 0;
      if (m_act) begin
        m_left--;
        if (m_left == 0) begin
          exp_ds   = to_disp(m_val, 1'b1);
          exp_dm   = to_disp(m_val, 1'b0);
          exp_ovf  = (m_val > 32'd99_999_999);
          exp_done = 1;
          if (wr_en) begin
            m_val = wr_data; m_left = 33; m_pend = 0;
          end else if (m_pend) begin
            m_val = m_pval; m_left = 33; m_pend = 0;
          end else begin
            m_act = 0;
          end
        end else if (wr_en) begin
          m_pend = 1; m_pval = wr_data;
        end
      end else if (wr_en) begin
        m_act = 1; m_val = wr_data; m_left = 33;
      end
      exp_busy = m_act || m_pend;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy_s", busy_s, exp_busy);
    chk("done_s", done_s, exp_done);
    chk("ovf_s", ovf_s, exp_ovf);
    chk("disp_s", disp_s(), exp_ds);
    chk("busy_m", busy_m, exp_busy);
    chk("done_m", done_m, exp_done);
    chk("ovf_m", ovf_m, exp_ovf);
    chk("disp_m", disp_m(), exp_dm);
    chk("hex_upper_bits", upper_bits(), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] es,
                           input logic [31:0] em, input logic eo, input logic eb);
    int c = 0;
    bit seen = 0;
    while (c < 80 && !seen) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      seen = done_s;
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, " latency"}, c, exp_lat);
      chk({name, " digits_sat"}, disp_s(), es);
      chk({name, " digits_mod"}, disp_m(), em);
      chk({name, " ovf_sat"}, ovf_s, eo);
      chk({name, " ovf_mod"}, ovf_m, eo);
      chk({name, " busy"}, busy_s, eb);
    end
    tick();
  endtask

  initial begin
    int nd;
    chk("model_ffffffff", to_disp(32'hFFFF_FFFF, 1'b0), 32'h9496_7295);
    chk("model_sat", to_disp(32'd100_000_000, 1'b1), 32'h9999_9999);
    chk("model_12345678", to_disp(32'd12_345_678, 1'b0), 32'h1234_5678);

    repeat (3) tick();
    chk("reset_digits", disp_s(), 32'd0);
    chk("reset_busy", busy_s, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    write(32'd0);
    wait_done("zero", 33, 32'h0, 32'h0, 1'b0, 1'b0);
    write(32'd12_345_678);
    wait_done("d12345678", 33, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    repeat (3) tick();
    write(32'd99_999_999);
    wait_done("d99999999", 33, 32'h9999_9999, 32'h9999_9999, 1'b0, 1'b0);
    write(32'd100_000_000);
    wait_done("d100000000", 33, 32'h9999_9999, 32'h0000_0000, 1'b1, 1'b0);
    write(32'hFFFF_FFFF);
    wait_done("ffffffff", 33, 32'h9999_9999, 32'h9496_7295, 1'b1, 1'b0);

    write(32'd111);
    repeat (4) tick();
    write(32'd222);
    repeat (4) tick();
    write(32'd333);
    wait_done("pend_first", 23, 32'h0000_0111, 32'h0000_0111, 1'b0, 1'b1);
    wait_done("pend_latest", 32, 32'h0000_0333, 32'h0000_0333, 1'b0, 1'b0);

    write(32'd42);
    repeat (9) tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_digits", disp_m(), 32'd0);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_done", done_m, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s || done_m) nd++;
    end
    chk("abort_no_done", nd, 0);
    tick();
    write(32'd7);
    wait_done("after_reset", 33, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_led_ctrl.md
Name: seven_led_ctrl

Overview:
- Sequencing controller in front of the 8-digit seven-segment decoder.
- Accepts a 32-bit unsigned binary value from the LSU/IO write path and converts it to 8 decimal digits with a multi-cycle double-dabble (shift-add-3) engine.
- Presents the digits as stable registered 7-bit nibble buses for the decoder inputs. Those buses update atomically only when a conversion completes, so the display never shows intermediate values.
- Handles overflow above 8 decimal digits and writes that arrive while a conversion is running.

Parameters:
- DATA_W, 32, width of the binary input value; the design is only verified at 32.
- SAT_EN, 1, overflow policy: 1 = saturate the display to 99999999, 0 = show value mod 10^8.
- MAX_VAL, 99_999_999, largest value displayable without overflow.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_ni  in  1  asynchronous active-low reset.
- i_wr_en  in  1  write strobe, one cycle per write.
- i_wr_data  in  DATA_W  unsigned binary value to display.
- o_busy  out  1  a conversion is running or a write is pending.
- o_done  out  1  one-cycle pulse in the cycle the new digits first appear.
- o_ovf  out  1  the last completed value exceeded MAX_VAL; registered and held until the next completion.
- o_hex0..o_hex7  out  7 each  decimal digit 0-9 in bits [3:0], bits [6:4] = 0. o_hex0 is the least significant digit.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_ni is asynchronous and active-low.
- Reset values:
  - all o_hexN = 0, so the display reads "00000000";
  - o_ovf = 0, o_done = 0, o_busy = 0;
  - state = IDLE, pending flag cleared.
- FSM states:
  - IDLE: if i_wr_en is high, capture i_wr_data into the shift register and compute ovf_q = (data > MAX_VAL). Clear the 40-bit BCD register and set cnt = 0. Go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by 1 and increment cnt. After the step with cnt = DATA_W-1, go to LOAD. Exactly 32 CONV cycles.
  - LOAD: update o_hex7..o_hex0 from BCD[31:0] (SAT_EN=0) or all 9 if ovf_q && SAT_EN. Set o_ovf = ovf_q and pulse o_done = 1 in the following cycle.
    - If i_wr_en is high in LOAD: accept it directly into CONV and discard any pending value.
    - Else if pending is valid: start CONV with the pending data and clear pending.
    - Otherwise go to IDLE.
- Latency: a write sampled at edge E0 yields new outputs and o_done high in the cycle after edge E33, i.e. 33 cycles later. Latency is fixed and independent of value or overflow.
- Writes while busy (in CONV): stored in a 1-deep pending register. A later write overwrites an earlier one (latest wins). Writes are never stalled or dropped, except when superseded by a newer write.
- o_busy = (state != IDLE) || pending_valid. It deasserts in the same cycle o_done pulses, when nothing is queued.
- Arithmetic:
  - BCD register is 40 bits (10 digits) so 2^32-1 = 4294967295 converts exactly.
  - Overflow compare is unsigned against MAX_VAL.
  - Upper two BCD digits are used only implicitly, through the ovf test.
- Outputs hold their last completed value indefinitely; o_done is 0 except for the single pulse cycle.
- Reset mid-conversion aborts immediately:
  - outputs return to reset values;
  - the pending write is lost;
  - no o_done pulse is generated.

Decomposition:
- Shared package seven_led_pkg holds:
  - the state enum (IDLE, CONV, LOAD);
  - BCD_DIGITS = 10, DISP_DIGITS = 8;
  - the MAX_VAL default.
- One natural sub-module, bcd_add3_step: combinational per-nibble ">=5 then +3" correction over 10 digits. The FSM instantiates it once and shifts its result.

Test Plan:
- Reset, then write 0 -> after 33 cycles o_done = 1 for 1 cycle, all o_hexN = 0, o_ovf = 0, o_busy low afterwards.
- Write 12345678 -> o_hex7..o_hex0 = 1,2,3,4,5,6,7,8 in the o_done cycle, o_ovf = 0; bits [6:4] of every digit are 0.
- Write 99999999 -> all digits 9, o_ovf = 0. Then write 100000000 with SAT_EN=1 -> all digits 9, o_ovf = 1.
- SAT_EN=0, write 0xFFFFFFFF -> digits 9,4,9,6,7,2,9,5 (hex7..hex0), o_ovf = 1.
- Write 111 at E0, 222 at E5, 333 at E10 -> o_done at E33 shows 111; the next conversion shows 333 (222 superseded); o_busy stays high in between.
- Write 42, assert i_rst_ni = 0 at E10 -> outputs immediately all 0, no o_done. After release, write 7 -> normal 33-cycle completion showing 00000007.
